mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter MEM_HS, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 Parameter ALUC_W, default 3, legal range 3..4: ALU control width; codes are zero-extended to ALUC_W.
REQ-003 Parameter EN_BNE, default 1: 1 = BNE (000101) decoded; 0 = BNE is illegal.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Ports op and funct, input, 6 each: instruction fields taken from the IR.
REQ-007 Port mem_ready, input, 1: memory completes the current access this cycle.
REQ-008 Port mem_req, output, 1: memory access requested.
REQ-009 Ports reg_write, alu_src_a, ior_d, mem_write, ir_write, reg_dst, mem_to_reg, pc_write, output, 1 each: datapath strobes and selects.
REQ-010 Ports alu_src_b and pc_src, output, 2 each: mux selects; pc_src 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-011 Port alu_ctrl, output, ALUC_W: ALU operation code.
REQ-012 Port br_cond, output, 2: branch condition; 00 none, 01 eq, 10 ne, 11 gtz; the datapath computes pc_write_cond.
REQ-013 Port imm_zext, output, 1: 1 = zero-extend the immediate; 0 = sign-extend.
REQ-014 Port illegal, output, 1: one-cycle pulse on an undecodable op or funct.
REQ-015 Port state_o, output, 4: current state, for debug.

Function
REQ-016 The FSM SHALL be Moore; all outputs are decoded from the state register and the latched funct/op, and are 0 unless listed for that state.
REQ-017 States SHALL be IDLE, FETCH, DECODE, MADR, MRD, MWB, MWR, REXE, RWB, BR, IEXE, IWB, JMP, ILL.
REQ-018 IDLE: all outputs 0; next state FETCH.
REQ-019 FETCH: mem_req=1, alu_src_b=01, alu_ctrl=010; ir_write=1 and pc_write=1 only when mem_ready; stay in FETCH while !mem_ready, otherwise go to DECODE.
REQ-020 DECODE: alu_src_b=11, alu_ctrl=010; latch op and funct; go to MADR for LW/SW, REXE for R, BR for BEQ/BNE/BGTZ, IEXE for ADDI/ANDI/ORI/SLTI, JMP for J, otherwise ILL.
REQ-021 MADR: alu_src_a=1, alu_src_b=10, alu_ctrl=010; go to MRD for LW, MWR for SW.
REQ-022 MRD: mem_req=1, ior_d=1; wait for mem_ready, then go to MWB.
REQ-023 MWB: reg_write=1, mem_to_reg=1; then FETCH.
REQ-024 MWR: mem_req=1, ior_d=1, mem_write=1; hold all of these until mem_ready, then go to FETCH.
REQ-025 REXE: alu_src_a=1, alu_src_b=00; funct decode: add 010, sub 110, and 000, or 001, slt 111; any other funct goes to ILL instead of RWB.
REQ-026 RWB: reg_write=1, reg_dst=1; then FETCH.
REQ-027 BR: alu_src_a=1, alu_ctrl=110, pc_src=01, br_cond per op; then FETCH.
REQ-028 IEXE: alu_src_a=1, alu_src_b=10; alu_ctrl addi 010, andi 000, ori 001, slti 111; imm_zext=1 for ANDI/ORI only.
REQ-029 IWB: reg_write=1, imm_zext held; then FETCH.
REQ-030 JMP: pc_src=10, pc_write=1; then FETCH.
REQ-031 ILL: illegal=1; then FETCH; the PC has already advanced.
REQ-032 With MEM_HS=0, every memory state SHALL last exactly one cycle.
REQ-033 An unreachable state encoding SHALL go to IDLE.

Reset
REQ-034 rst_n low SHALL asynchronously force state to IDLE and clear the latched op/funct; all outputs 0 while rst_n is low.
REQ-035 Deassertion SHALL be followed by one IDLE cycle, then FETCH.
REQ-036 Reset mid-access SHALL drop mem_req and mem_write immediately.

Structure
REQ-037 A shared package SHALL hold the state enum, opcode/funct constants, ALU codes and br_cond codes.
REQ-038 The design SHALL have one sub-module, mc_alu_decode: combinational mapping of (state, op, funct) to alu_ctrl and the illegal flag.

Verification
REQ-039 Reset: rst_n low mid-MWR -> mem_write=0 at once; after release, IDLE for 1 cycle, then FETCH.
REQ-040 LW with MEM_HS=1, mem_ready low 2 cycles in FETCH and 3 cycles in MRD -> exactly one ir_write pulse, MWB reached; total 10 cycles FETCH..MWB.
REQ-041 R sub (funct 100010) -> REXE alu_ctrl=110, RWB reg_dst=1; 4 cycles with mem_ready tied 1.
REQ-042 BNE with EN_BNE=1 -> BR br_cond=10; with EN_BNE=0 -> ILL with one illegal pulse, then FETCH.
REQ-043 ORI -> imm_zext=1 in IEXE and IWB, alu_ctrl=001; ADDI -> imm_zext=0.
REQ-044 R funct 000000 -> ILL, no reg_write; MEM_HS=0 with mem_ready held 0 -> LW completes in 5 cycles.

Source files
------------

// File: rtl/mc_control_unit_pkg.sv
// Shared types and encodings for the multicycle control unit.
package mc_control_unit_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned ALU_CODE_W = 3;
  localparam int unsigned BRC_W      = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MADR   = 4'd3,
    S_MRD    = 4'd4,
    S_MWB    = 4'd5,
    S_MWR    = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_BR     = 4'd9,
    S_IEXE   = 4'd10,
    S_IWB    = 4'd11,
    S_JMP    = 4'd12,
    S_ILL    = 4'd13
  } state_e;

  // Opcodes
  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_BGTZ = 6'b000111;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

  // R-type funct codes
  localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

  // ALU operation codes (zero-extended to the configured width at the port)
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

  // Branch conditions evaluated by the datapath
  localparam logic [BRC_W-1:0] BRC_NONE = 2'b00;
  localparam logic [BRC_W-1:0] BRC_EQ   = 2'b01;
  localparam logic [BRC_W-1:0] BRC_NE   = 2'b10;
  localparam logic [BRC_W-1:0] BRC_GTZ  = 2'b11;

  // Branch condition selected by a branch opcode
  function automatic logic [BRC_W-1:0] br_cond_of(input logic [OP_W-1:0] op);
    logic [BRC_W-1:0] c;
    c = BRC_NONE;
    case (op)
      OP_BEQ:  c = BRC_EQ;
      OP_BNE:  c = BRC_NE;
      OP_BGTZ: c = BRC_GTZ;
      default: c = BRC_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU-control and legality decode for the multicycle control unit.
module mc_alu_decode
  import mc_control_unit_pkg::*;
#(
  parameter int unsigned ALUC_W = 3,
  parameter int unsigned EN_BNE = 1
) (
  input  logic [STATE_W-1:0] state,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUC_W-1:0]  alu_ctrl_c,
  output logic               illegal_c
);

  logic [ALU_CODE_W-1:0] code;

  // ALU code per state; flags undecodable op in DECODE and funct in REXE
  always_comb begin
    code      = ALU_AND;
    illegal_c = 1'b0;
    case (state)
      S_FETCH, S_MADR: code = ALU_ADD;
      S_DECODE: begin
        code = ALU_ADD;
        case (op)
          OP_R, OP_J, OP_BEQ, OP_BGTZ, OP_ADDI, OP_SLTI,
          OP_ANDI, OP_ORI, OP_LW, OP_SW: illegal_c = 1'b0;
          OP_BNE:  illegal_c = (EN_BNE == 0);
          default: illegal_c = 1'b1;
        endcase
      end
      S_REXE: begin
        case (funct)
          F_ADD:   code = ALU_ADD;
          F_SUB:   code = ALU_SUB;
          F_AND:   code = ALU_AND;
          F_OR:    code = ALU_OR;
          F_SLT:   code = ALU_SLT;
          default: illegal_c = 1'b1;
        endcase
      end
      S_BR: code = ALU_SUB;
      S_IEXE: begin
        case (op)
          OP_ADDI: code = ALU_ADD;
          OP_ANDI: code = ALU_AND;
          OP_ORI:  code = ALU_OR;
          OP_SLTI: code = ALU_SLT;
          default: code = ALU_AND;
        endcase
      end
      default: code = ALU_AND;
    endcase
  end

  assign alu_ctrl_c = ALUC_W'(code);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-style Moore control unit with optional memory handshake.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int unsigned MEM_HS = 1,
  parameter int unsigned ALUC_W = 3,
  parameter int unsigned EN_BNE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic              ior_d,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              pc_write,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        pc_src,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic [1:0]        br_cond,
  output logic              imm_zext,
  output logic              illegal,
  output logic [3:0]        state_o
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d, op_dec;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic               rdy;
  logic               dec_illegal;
  logic               zext_op;

  // Without handshake every memory access completes in one cycle
  assign rdy = (MEM_HS == 0) ? 1'b1 : mem_ready;

  // DECODE classifies the live IR op; later states use the latched copy
  assign op_dec  = (state_q == S_DECODE) ? op : op_q;
  assign zext_op = (op_q == OP_ANDI) || (op_q == OP_ORI);

  mc_alu_decode #(
    .ALUC_W (ALUC_W),
    .EN_BNE (EN_BNE)
  ) u_alu_decode (
    .state      (state_q),
    .op         (op_dec),
    .funct      (funct_q),
    .alu_ctrl_c (alu_ctrl),
    .illegal_c  (dec_illegal)
  );

  // State register and latched instruction fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

  // Next-state and field-latch logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = op;
        funct_d = funct;
        if (dec_illegal) begin
          state_d = S_ILL;
        end else begin
          case (op)
            OP_LW, OP_SW:                    state_d = S_MADR;
            OP_R:                            state_d = S_REXE;
            OP_BEQ, OP_BNE, OP_BGTZ:         state_d = S_BR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXE;
            OP_J:                            state_d = S_JMP;
            default:                         state_d = S_ILL;
          endcase
        end
      end
      S_MADR:  state_d = (op_q == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   if (rdy) state_d = S_MWB;
      S_MWR:   if (rdy) state_d = S_FETCH;
      S_REXE:  state_d = dec_illegal ? S_ILL : S_RWB;
      S_IEXE:  state_d = S_IWB;
      S_MWB, S_RWB, S_BR, S_IWB, S_JMP, S_ILL: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the state register and latched op
  always_comb begin
    mem_req    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    ior_d      = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    br_cond    = BRC_NONE;
    imm_zext   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MRD: begin
        mem_req = 1'b1;
        ior_d   = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MWR: begin
        mem_req   = 1'b1;
        ior_d     = 1'b1;
        mem_write = 1'b1;
      end
      S_REXE: alu_src_a = 1'b1;
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        pc_src    = 2'b01;
        br_cond   = br_cond_of(op_q);
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        imm_zext  = zext_op;
      end
      S_IWB: begin
        reg_write = 1'b1;
        imm_zext  = zext_op;
      end
      S_JMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_ILL:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  assign state_o = 4'(state_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench: three configurations of the control unit share one stimulus stream.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       mem_ready;

  int ncmp = 0;
  int nerr = 0;

  // a_: defaults; b_: EN_BNE=0 with 4-bit ALU control; c_: MEM_HS=0
  logic a_mem_req, a_reg_write, a_alu_src_a, a_ior_d, a_mem_write, a_ir_write;
  logic a_reg_dst, a_mem_to_reg, a_pc_write, a_imm_zext, a_illegal;
  logic [1:0] a_alu_src_b, a_pc_src, a_br_cond;
  logic [2:0] a_alu_ctrl;
  logic [3:0] a_state;

  logic b_mem_req, b_reg_write, b_alu_src_a, b_ior_d, b_mem_write, b_ir_write;
  logic b_reg_dst, b_mem_to_reg, b_pc_write, b_imm_zext, b_illegal;
  logic [1:0] b_alu_src_b, b_pc_src, b_br_cond;
  logic [3:0] b_alu_ctrl;
  logic [3:0] b_state;

  logic c_mem_req, c_reg_write, c_alu_src_a, c_ior_d, c_mem_write, c_ir_write;
  logic c_reg_dst, c_mem_to_reg, c_pc_write, c_imm_zext, c_illegal;
  logic [1:0] c_alu_src_b, c_pc_src, c_br_cond;
  logic [2:0] c_alu_ctrl;
  logic [3:0] c_state;

  always #5 clk = ~clk;

  mc_control_unit u_a (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .reg_write(a_reg_write), .alu_src_a(a_alu_src_a),
    .ior_d(a_ior_d), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .pc_write(a_pc_write),
    .alu_src_b(a_alu_src_b), .pc_src(a_pc_src), .alu_ctrl(a_alu_ctrl),
    .br_cond(a_br_cond), .imm_zext(a_imm_zext), .illegal(a_illegal), .state_o(a_state)
  );

  mc_control_unit #(.MEM_HS(1), .ALUC_W(4), .EN_BNE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .reg_write(b_reg_write), .alu_src_a(b_alu_src_a),
    .ior_d(b_ior_d), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .pc_write(b_pc_write),
    .alu_src_b(b_alu_src_b), .pc_src(b_pc_src), .alu_ctrl(b_alu_ctrl),
    .br_cond(b_br_cond), .imm_zext(b_imm_zext), .illegal(b_illegal), .state_o(b_state)
  );

  mc_control_unit #(.MEM_HS(0), .ALUC_W(3), .EN_BNE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(c_mem_req), .reg_write(c_reg_write), .alu_src_a(c_alu_src_a),
    .ior_d(c_ior_d), .mem_write(c_mem_write), .ir_write(c_ir_write),
    .reg_dst(c_reg_dst), .mem_to_reg(c_mem_to_reg), .pc_write(c_pc_write),
    .alu_src_b(c_alu_src_b), .pc_src(c_pc_src), .alu_ctrl(c_alu_ctrl),
    .br_cond(c_br_cond), .imm_zext(c_imm_zext), .illegal(c_illegal), .state_o(c_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; leaves us at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // LW walk: expected state and mem_ready per cycle, FETCH through MWB
  logic [3:0] lw_st  [10] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
  logic       lw_rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       lw_req [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  int irw_cnt;

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; op = 6'b000000; funct = 6'b000000;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", a_state, 0);
    chk("rst_mem_req", a_mem_req, 0);
    chk("rst_pc_write", a_pc_write, 0);

    // Release: one IDLE cycle, then FETCH
    rst_n = 1'b1;
    op = 6'b100011;
    chk("rel_idle", a_state, 0);
    tick();

    // LW with 2 wait cycles in FETCH and 3 in MRD
    irw_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = lw_rdy[i];
      #1;
      chk($sformatf("lw_state_%0d", i), a_state, lw_st[i]);
      chk($sformatf("lw_req_%0d", i), a_mem_req, lw_req[i]);
      if (a_ir_write === 1'b1) irw_cnt++;
      if (i < 9) tick();
    end
    chk("lw_irw_pulses", irw_cnt, 1);
    chk("lw_mwb_regw", a_reg_write, 1);
    chk("lw_mwb_m2r", a_mem_to_reg, 1);
    tick();

    // R-type SUB: FETCH, DECODE, REXE, RWB
    op = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
    #1;
    chk("sub_fetch", a_state, 1);
    chk("sub_fetch_irw", a_ir_write, 1);
    tick();
    chk("sub_decode_srcb", a_alu_src_b, 2'b11);
    tick();
    chk("sub_rexe_state", a_state, 7);
    chk("sub_rexe_alu", a_alu_ctrl, 3'b110);
    chk("sub_rexe_alu_w4", b_alu_ctrl, 4'b0110);
    chk("sub_rexe_srca", a_alu_src_a, 1);
    tick();
    chk("sub_rwb_dst", a_reg_dst, 1);
    chk("sub_rwb_regw", a_reg_write, 1);
    tick();
    chk("sub_back_fetch", a_state, 1);

    // BNE: branch when enabled, illegal when disabled
    op = 6'b000101;
    tick();
    tick();
    chk("bne_a_state", a_state, 9);
    chk("bne_a_brc", a_br_cond, 2'b10);
    chk("bne_a_pcsrc", a_pc_src, 2'b01);
    chk("bne_a_alu", a_alu_ctrl, 3'b110);
    chk("bne_b_state", b_state, 13);
    chk("bne_b_illegal", b_illegal, 1);
    tick();
    chk("bne_b_fetch", b_state, 1);
    chk("bne_b_ill_drop", b_illegal, 0);

    // ORI: zero-extended immediate in IEXE and IWB
    op = 6'b001101;
    tick();
    tick();
    chk("ori_iexe_state", a_state, 10);
    chk("ori_iexe_zext", a_imm_zext, 1);
    chk("ori_iexe_alu", a_alu_ctrl, 3'b001);
    chk("ori_iexe_srcb", a_alu_src_b, 2'b10);
    tick();
    chk("ori_iwb_zext", a_imm_zext, 1);
    chk("ori_iwb_regw", a_reg_write, 1);
    tick();

    // ADDI: sign-extended immediate
    op = 6'b001000;
    tick();
    tick();
    chk("addi_iexe_zext", a_imm_zext, 0);
    chk("addi_iexe_alu", a_alu_ctrl, 3'b010);
    tick();
    chk("addi_iwb_zext", a_imm_zext, 0);
    tick();

    // R-type with undefined funct: REXE then ILL, never writes back
    op = 6'b000000; funct = 6'b000000;
    tick();
    tick();
    chk("badf_rexe_regw", a_reg_write, 0);
    tick();
    chk("badf_ill_state", a_state, 13);
    chk("badf_ill_flag", a_illegal, 1);
    chk("badf_ill_regw", a_reg_write, 0);
    tick();
    chk("badf_fetch", a_state, 1);
    chk("badf_ill_drop", a_illegal, 0);

    // Jump
    op = 6'b000010;
    tick();
    tick();
    chk("j_pcsrc", a_pc_src, 2'b10);
    chk("j_pcw", a_pc_write, 1);
    tick();

    // SW stalled in MWR, then reset mid-access
    op = 6'b101011;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("sw_madr_srca", a_alu_src_a, 1);
    tick();
    chk("sw_mwr_state", a_state, 6);
    chk("sw_mwr_memw", a_mem_write, 1);
    chk("sw_mwr_iord", a_ior_d, 1);
    tick();
    chk("sw_mwr_hold", a_mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("sw_rst_memw", a_mem_write, 0);
    chk("sw_rst_memreq", a_mem_req, 0);
    chk("sw_rst_state", a_state, 0);

    // Release, then LW with handshake disabled and mem_ready held low
    @(negedge clk);
    rst_n = 1'b1; op = 6'b100011; mem_ready = 1'b0;
    #1;
    chk("rel2_idle", a_state, 0);
    tick();
    chk("rel2_fetch", a_state, 1);
    chk("nohs_fetch", c_state, 1);
    chk("nohs_irw", c_ir_write, 1);
    chk("hs_fetch_irw", a_ir_write, 0);
    tick();
    chk("nohs_decode", c_state, 2);
    tick();
    chk("nohs_madr", c_state, 3);
    tick();
    chk("nohs_mrd", c_state, 4);
    chk("nohs_mrd_req", c_mem_req, 1);
    tick();
    chk("nohs_mwb", c_state, 5);
    chk("nohs_mwb_regw", c_reg_write, 1);
    chk("hs_still_fetch", a_state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
